digit_scan: RTL
===============

Name: digit_scan

Overview:
- Time-multiplexed digit scanner for the 7-segment indicator path.
- Holds a packed multi-digit value and presents one 3-bit digit per scan slot on `digit_out`. `digit_out` feeds the segment decoder's `Din` input directly.
- Drives a one-hot digit-select bus. The select bus is delayed one clock so that it lines up with the decoder's registered segment output.
- Includes a blanking interval per slot to suppress ghosting, and a frame-synchronous load so the display never tears.

Parameters:
- n, 8, width of `digit_out`; matches the decoder's input width.
- DIGITS, 4, number of multiplexed digits (2..8).
- DIV, 1000, clocks per digit slot (>= 2).
- BLANK, 16, clocks at the start of each slot with select forced off (0 <= BLANK < DIV).

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  scan enable; low blanks the display and parks the scanner.
- load  input  1  one-cycle request to capture `data_in`.
- data_in  input  3*DIGITS  packed digits; digit k = `data_in[3k+2:3k]`; digit 0 = rightmost.
- digit_out  output  n  current digit, zero-extended to n bits; goes to decoder `Din`.
- sel  output  DIGITS  one-hot digit enable, active-high, aligned with decoder output.
- load_ack  output  1  one-cycle pulse when a loaded value becomes active.

Behaviour:
- Reset (`reset_n` low, async):
  - `digit_out`=0, `sel`=0, `load_ack`=0.
  - `active`=0, `pending`=0, `pend_valid`=0.
  - `idx`=0, `presc`=0, `sel_pre`=0.
- Releasing reset starts scanning at slot 0, `presc`=0, on the first enabled clock.
- Prescaler: `presc` counts 0..DIV-1, then wraps to 0.
  - On wrap, `idx` advances; from DIGITS-1 it wraps to 0.
  - Frame boundary = the edge on which `idx`=DIGITS-1 and `presc`=DIV-1.
- `digit_out`:
  - Registered; equals `{ (n-3) zeros, active[3*idx +: 3] }`.
  - Updated on the same edge that updates `idx`, so it is stable for the whole slot.
- Slot phases:
  - BLANK phase: `presc` < BLANK.
  - SHOW phase: `presc` >= BLANK.
- `sel_pre`:
  - BLANK phase: `sel_pre`=0.
  - SHOW phase: `sel_pre`=onehot(`idx`).
  - `sel` <= `sel_pre` (one-clock delay = decoder latency).
- Load handshake:
  - `load`=1 and not at a frame boundary: `pending` <= `data_in`, `pend_valid` <= 1. A later load overwrites `pending` (last value wins); there is no ack for overwritten values.
  - Frame boundary with `pend_valid`=1: `active` <= `pending`, `pend_valid` <= 0, `load_ack`=1 for exactly one cycle.
  - Frame boundary with `load`=1 on the same edge: `active` <= `data_in` directly (bypass; `load` has priority over `pending`), `pend_valid` <= 0, `load_ack`=1.
  - No pending and no load at a boundary: `active` unchanged, `load_ack`=0.
- Enable:
  - `enable`=0: `presc`, `idx` and `sel_pre` are held at 0, so `sel`=0 one clock later. `digit_out` shows digit 0.
  - Loads are still captured into `pending` but are not transferred.
  - When `enable` returns to 1, the scanner restarts at slot 0 / BLANK phase.
  - Since `presc`=0, `idx`=0 at restart, that first cycle is a frame boundary only if DIGITS=1 (excluded by the parameter range).
- `active` only changes at frame boundaries, so every frame shows a single coherent value.
- Reset asserted mid-frame: all state is cleared immediately. Pending data is lost and no ack is issued.
- Invariant: at most one bit of `sel` is high on any cycle.

Test Plan:
- Run with DIGITS=4, DIV=8, BLANK=2 (frame = 32 clocks).
- Reset, then release with `enable`=1, `data_in`=12'o7531, `load` pulse at cycle 3:
  - `load_ack` pulses at cycle 31.
  - Frame 2 shows `digit_out`=1,3,5,7 for `idx`=0..3.
  - `sel` sequence: 0001, 0010, 0100, 1000, each high for 6 clocks after 2 blank clocks.
  - `sel` lags the slot start by 3 clocks total (2 blank + 1 align).
- Two loads in one frame (12'o0123 at cycle 40, 12'o4444 at cycle 50):
  - Exactly one `load_ack` at cycle 63.
  - The following frame shows 4,4,4,4.
- `load` asserted exactly on the frame-boundary edge with 12'o2222, `pend_valid`=1 holding 12'o6666:
  - `active`=12'o2222 (bypass).
  - `load_ack`=1 for one cycle; `pend_valid`=0.
- `enable` dropped mid-slot 2:
  - `sel`=0 on the next clock; `presc`/`idx`=0.
  - After re-enable, the first `sel`=0001 appears 3 clocks later.
- Assert `reset_n`=0 asynchronously between clock edges while a load is pending:
  - All outputs go to 0 immediately.
  - After release, no `load_ack` occurs and `digit_out`=0.
- Check across all tests:
  - `sel` is never multi-hot.
  - `digit_out[n-1:3]` is always 0.

Source files
------------

// File: rtl/digit_scan.sv
// Time-multiplexed scanner: one 3-bit digit per slot on digit_out, one-hot select
// delayed a clock to match the decoder register, frame-synchronous value load.
module digit_scan #(
   parameter int n      = 8,
   parameter int DIGITS = 4,
   parameter int DIV    = 1000,
   parameter int BLANK  = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  load,
   input  logic [3*DIGITS-1:0]   data_in,
   output logic [n-1:0]          digit_out,
   output logic [DIGITS-1:0]     sel,
   output logic                  load_ack
);

   localparam int PW = $clog2(DIV);
   localparam int IW = $clog2(DIGITS);

   logic [3*DIGITS-1:0] r_active;
   logic [3*DIGITS-1:0] r_pending;
   logic                r_pend_valid;
   logic [IW-1:0]       r_idx;
   logic [PW-1:0]       r_presc;
   logic [DIGITS-1:0]   r_sel_pre;
   logic [DIGITS-1:0]   r_sel;
   logic [n-1:0]        r_digit;
   logic                r_ack;

   logic                w_wrap;
   logic                w_frame;
   logic [PW-1:0]       w_presc_nxt;
   logic [IW-1:0]       w_idx_nxt;
   logic [3*DIGITS-1:0] w_active_nxt;
   logic [3*DIGITS-1:0] w_shifted;
   logic [DIGITS-1:0]   w_sel_pre_nxt;

   assign w_wrap  = (r_presc == PW'(DIV - 1));
   assign w_frame = enable && w_wrap && (r_idx == IW'(DIGITS - 1));

   // digit_out and sel_pre are computed from the next slot position so they
   // change on the same edge as idx/presc rather than a cycle later.
   always_comb begin
      w_presc_nxt   = '0;
      w_idx_nxt     = '0;
      w_active_nxt  = r_active;
      w_sel_pre_nxt = '0;
      if (enable) begin
         if (w_wrap) begin
            w_idx_nxt = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
         end else begin
            w_presc_nxt = r_presc + 1'b1;
            w_idx_nxt   = r_idx;
         end
         if (int'(w_presc_nxt) >= BLANK)
            w_sel_pre_nxt = DIGITS'(1) << w_idx_nxt;
      end
      if (w_frame) begin
         if (load)
            w_active_nxt = data_in;
         else if (r_pend_valid)
            w_active_nxt = r_pending;
      end
      w_shifted = w_active_nxt >> (3 * w_idx_nxt);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_active     <= '0;
         r_pending    <= '0;
         r_pend_valid <= 1'b0;
         r_idx        <= '0;
         r_presc      <= '0;
         r_sel_pre    <= '0;
         r_sel        <= '0;
         r_digit      <= '0;
         r_ack        <= 1'b0;
      end else begin
         r_presc   <= w_presc_nxt;
         r_idx     <= w_idx_nxt;
         r_sel_pre <= w_sel_pre_nxt;
         r_sel     <= r_sel_pre;
         r_active  <= w_active_nxt;
         r_digit   <= n'(w_shifted[2:0]);
         r_ack     <= w_frame && (load || r_pend_valid);
         if (w_frame) begin
            r_pend_valid <= 1'b0;
         end else if (load) begin
            r_pending    <= data_in;
            r_pend_valid <= 1'b1;
         end
      end
   end

   assign digit_out = r_digit;
   assign sel       = r_sel;
   assign load_ack  = r_ack;

endmodule
